fetch_stage: RTL

Instruction-fetch stage with its IF/ID pipeline register: it owns the PC, drives the instruction-memory address and registers the fetched word into `IR_OUT` for the decode stage. Decode resolves branches and jumps in ID and returns the taken target on `redirect`/`redirect_pc`. The block handles memory wait states, hazard stalls and redirects, and compiles in optional MIPS branch-delay-slot semantics.

---
 rtl/fetch_stage.sv | 73 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with stall, redirect and memory wait-state handling.
// Define FETCH_DELAY_SLOT_EN to build MIPS branch-delay-slot semantics (adds SLOT_WAIT and saved_target).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  output logic [31:0] IR_OUT,
  output logic [31:0] PC4_OUT,
  output logic        valid_out
);
  logic [31:0] pc_q, pc_d, ir_q, ir_d, pc4_q, pc4_d, target, pc_inc;
  logic        valid_q, valid_d, take;
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc = pc_q + 32'd4;
`ifdef FETCH_DELAY_SLOT_EN
  typedef enum logic {NORMAL, SLOT_WAIT} state_t;
  state_t      state_q, state_d;
  logic [31:0] saved_q, saved_d;
  logic        slot;
  assign slot = state_q == SLOT_WAIT;
  // The word after a branch always executes, so any ready word is captured.
  assign take = imem_ready;
  always_comb begin
    state_d = stall ? state_q : slot ? (imem_ready ? NORMAL : SLOT_WAIT)
            : (redirect && !imem_ready) ? SLOT_WAIT : NORMAL;
    saved_d = (!stall && !slot && redirect && !imem_ready) ? target : saved_q;
    pc_d    = (stall || !imem_ready) ? pc_q : slot ? saved_q : redirect ? target : pc_inc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end
`else
  // The wrong-path word fetched alongside a redirect is squashed.
  assign take = imem_ready && !redirect;
  always_comb pc_d = stall ? pc_q : redirect ? target : imem_ready ? pc_inc : pc_q;
`endif
  always_comb begin
    ir_d    = stall ? ir_q : take ? imem_data : NOP;
    pc4_d   = stall ? pc4_q : take ? pc_inc : '0;
    valid_d = stall ? valid_q : take;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign imem_addr = pc_q;
  assign IR_OUT    = ir_q;
  assign PC4_OUT   = pc4_q;
  assign valid_out = valid_q;
endmodule
